// File: rtl/riscv_pmp_arbiter_pkg.sv
// rtl/riscv_pmp_arbiter_pkg.sv - shared types for the PMP checker arbiter
package riscv_pmp_arbiter_pkg;

    // Bus transfer size encoding seen by the PMP checker
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

    // Which requester a pipelined check belongs to
    typedef enum logic {
        PMP_SRC_IF = 1'b0,
        PMP_SRC_DM = 1'b1
    } pmp_src_t;

endpackage

// File: rtl/riscv_pmp_arb_sel.sv
// rtl/riscv_pmp_arb_sel.sv - IF/DM winner selection; PMP_ARB_RR_EN selects round-robin
module riscv_pmp_arb_sel
    import riscv_pmp_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic blk_i,
    output logic if_gnt_o,
    output logic dm_gnt_o
);

`ifdef PMP_ARB_RR_EN
    pmp_src_t last_q, last_d;
    logic     if_win;

    // On contention the requester that did not win last time is granted
    always_comb begin
        if_win   = if_req_i & (~dm_req_i | (last_q == PMP_SRC_DM));
        if_gnt_o = ~blk_i & if_win;
        dm_gnt_o = ~blk_i & dm_req_i & ~if_win;
        last_d   = last_q;
        if (if_gnt_o)      last_d = PMP_SRC_IF;
        else if (dm_gnt_o) last_d = PMP_SRC_DM;
    end

    // Last-winner pointer starts at DM so IF takes the first contention
    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= PMP_SRC_DM;
        else       last_q <= last_d;
    end
`else
    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             if_win;

    // DM has priority unless IF has lost STARVE_MAX arbitrations in a row
    always_comb begin
        if_win   = if_req_i & (~dm_req_i | (cnt_q == CNT_MAX));
        if_gnt_o = ~blk_i & if_win;
        dm_gnt_o = ~blk_i & dm_req_i & ~if_win;
        cnt_d    = cnt_q;
        if (if_gnt_o)                                   cnt_d = '0;
        else if (if_req_i && !blk_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    // Starvation counter; blocked cycles leave it untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

endmodule

// File: rtl/riscv_pmp_arbiter.sv
// rtl/riscv_pmp_arbiter.sv - shares one PMP checker between IF and DM (option: PMP_ARB_RR_EN)
module riscv_pmp_arbiter
    import riscv_pmp_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PLEN       = (XLEN == 32) ? 34 : 56,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [PLEN-1:0] if_adr_i,
    input  biu_size_t       if_size_i,
    output logic            if_gnt_o,
    output logic            if_rsp_vld_o,
    output logic            if_exception_o,
    input  logic            dm_req_i,
    input  logic [PLEN-1:0] dm_adr_i,
    input  biu_size_t       dm_size_i,
    input  logic            dm_we_i,
    output logic            dm_gnt_o,
    output logic            dm_rsp_vld_o,
    output logic            dm_exception_o,
    input  logic            flush_i,
    input  logic            pmp_upd_i,
    output logic            chk_req_o,
    output logic            chk_instruction_o,
    output logic [PLEN-1:0] chk_adr_o,
    output biu_size_t       chk_size_o,
    output logic            chk_we_o,
    input  logic            chk_exception_i
);

    logic            upd_q;
    logic            blk;
    logic            chk_req_q,  chk_req_d;
    pmp_src_t        chk_src_q,  chk_src_d;
    logic [PLEN-1:0] chk_adr_q,  chk_adr_d;
    biu_size_t       chk_size_q, chk_size_d;
    logic            chk_we_q,   chk_we_d;
    logic            rsp_vld_q,  rsp_vld_d;
    pmp_src_t        rsp_src_q,  rsp_src_d;
    logic            rsp_exc_q,  rsp_exc_d;

    // CSR writes block grants this cycle and the next so the checker sees settled state
    assign blk = rst_i | flush_i | pmp_upd_i | upd_q;

    riscv_pmp_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .if_req_i (if_req_i),
        .dm_req_i (dm_req_i),
        .blk_i    (blk),
        .if_gnt_o (if_gnt_o),
        .dm_gnt_o (dm_gnt_o)
    );

    // Capture the winner for the checker; response is killed by a flush in its check cycle
    always_comb begin
        chk_req_d  = if_gnt_o | dm_gnt_o;
        chk_src_d  = chk_src_q;
        chk_adr_d  = chk_adr_q;
        chk_size_d = chk_size_q;
        chk_we_d   = chk_we_q;
        if (if_gnt_o) begin
            chk_src_d  = PMP_SRC_IF;
            chk_adr_d  = if_adr_i;
            chk_size_d = if_size_i;
            chk_we_d   = 1'b0;
        end else if (dm_gnt_o) begin
            chk_src_d  = PMP_SRC_DM;
            chk_adr_d  = dm_adr_i;
            chk_size_d = dm_size_i;
            chk_we_d   = dm_we_i;
        end
        rsp_vld_d = chk_req_q & ~flush_i;
        rsp_src_d = chk_src_q;
        rsp_exc_d = chk_req_q & chk_exception_i;
    end

    // Pipeline registers; source resets to DM so chk_instruction_o reads 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_q      <= 1'b0;
            chk_req_q  <= 1'b0;
            chk_src_q  <= PMP_SRC_DM;
            chk_adr_q  <= '0;
            chk_size_q <= BYTE;
            chk_we_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_src_q  <= PMP_SRC_DM;
            rsp_exc_q  <= 1'b0;
        end else begin
            upd_q      <= pmp_upd_i;
            chk_req_q  <= chk_req_d;
            chk_src_q  <= chk_src_d;
            chk_adr_q  <= chk_adr_d;
            chk_size_q <= chk_size_d;
            chk_we_q   <= chk_we_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_src_q  <= rsp_src_d;
            rsp_exc_q  <= rsp_exc_d;
        end
    end

    assign chk_req_o         = chk_req_q;
    assign chk_instruction_o = (chk_src_q == PMP_SRC_IF);
    assign chk_adr_o         = chk_adr_q;
    assign chk_size_o        = chk_size_q;
    assign chk_we_o          = chk_we_q;

    assign if_rsp_vld_o   = rsp_vld_q & (rsp_src_q == PMP_SRC_IF);
    assign if_exception_o = if_rsp_vld_o & rsp_exc_q;
    assign dm_rsp_vld_o   = rsp_vld_q & (rsp_src_q == PMP_SRC_DM);
    assign dm_exception_o = dm_rsp_vld_o & rsp_exc_q;

endmodule
